// File: rtl/kb_pkg.sv
// rtl/kb_pkg.sv - shared encodings and constants for the PS/2 keyboard controller
package kb_pkg;

  // Receive FSM state encoding
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // STATUS word bit positions
  localparam int BIT_OVF  = 10;
  localparam int BIT_ERR  = 9;
  localparam int BIT_FULL = 8;

  // DATA word valid bit position
  localparam int BIT_VALID = 8;

  // Break (key release) prefix byte
  localparam logic [7:0] BREAK_CODE = 8'hF0;

  // Byte offsets inside the keyboard window (KB_START = 0x812D4)
  localparam logic [3:0] KB_DATA_OFS   = 4'h0;
  localparam logic [3:0] KB_STATUS_OFS = 4'h2;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/kb_fifo.sv
// rtl/kb_fifo.sv - synchronous scan-code FIFO with simultaneous push/pop on full
module kb_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          avail
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_n;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = ~avail;
  assign head  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside a pop
  always_comb begin
    do_pop  = pop & avail;
    do_push = push & (~full | do_pop);
    count_n = count;
    if (do_push && !do_pop) count_n = count + CNT_ONE;
    else if (do_pop && !do_push) count_n = count - CNT_ONE;
  end

  // Storage array; no reset needed since reads are qualified by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the registered non-empty flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      avail  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_n;
      avail <= (count_n != '0);
    end
  end

endmodule

// File: rtl/kb_controller.sv
// rtl/kb_controller.sv - PS/2 keyboard receiver with scan-code FIFO; optional KB_BREAK_FILTER_EN drops break sequences
module kb_controller
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int FIFO_AW     = 4,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd_en,
  input  logic        addr_sel,
  output logic [15:0] rdata,
  output logic        kb_avail
);

  localparam int FL_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic            clk_s1, clk_s2, dat_s1, dat_s2;
  logic            filt, filt_d;
  logic [FL_W-1:0] filt_cnt;
  logic            fall_evt;

  rx_state_t       state, state_n;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            frame_ok, frame_bad;

  logic            fifo_push, fifo_pop, stat_rd;
  logic [7:0]      fifo_head;
  logic [FIFO_AW:0] fifo_count;
  logic            fifo_full, fifo_empty;
  logic            ovf_flag, err_flag;
  logic [3:0]      ofs;
  logic [15:0]     data_word, status_word;

  // Two-stage synchronisers; reset to the idle-high bus level so no false edge follows reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      filt_d <= filt;
      if (clk_s2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FL_W'(FILTER_LEN - 1)) begin
        filt     <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FL_W'(1);
      end
    end
  end

  assign fall_evt = filt_d & ~filt;

  // RX state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_n;
  end

  // RX next-state and frame verdict; a timeout overrides everything except a coincident edge
  always_comb begin
    state_n   = state;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state)
      RX_IDLE:   if (fall_evt && !dat_s2) state_n = RX_DATA;
      RX_DATA:   if (fall_evt && bit_cnt == 3'd7) state_n = RX_PARITY;
      RX_PARITY: if (fall_evt) state_n = RX_STOP;
      RX_STOP: begin
        if (fall_evt) begin
          if (dat_s2 && odd_parity_ok(shreg, par_bit)) frame_ok = 1'b1;
          else frame_bad = 1'b1;
          state_n = RX_IDLE;
        end
      end
      default:   state_n = RX_IDLE;
    endcase
    if (state != RX_IDLE && !fall_evt && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
      state_n   = RX_IDLE;
      frame_bad = 1'b1;
    end
  end

  // RX datapath: bit counter, LSB-first shift register, parity capture and inactivity counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (fall_evt) begin
        case (state)
          RX_IDLE:   bit_cnt <= '0;
          RX_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          RX_PARITY: par_bit <= dat_s2;
          default:   ;
        endcase
      end
      if (state == RX_IDLE || fall_evt) to_cnt <= '0;
      else                              to_cnt <= to_cnt + TO_W'(1);
    end
  end

`ifdef KB_BREAK_FILTER_EN
  logic drop_next;

  assign fifo_push = frame_ok && (shreg != BREAK_CODE) && !drop_next;

  // Swallow 0xF0 and the byte after it; any bad or aborted frame forgets the pending drop
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          drop_next <= 1'b0;
    else if (frame_bad) drop_next <= 1'b0;
    else if (frame_ok)  drop_next <= (shreg == BREAK_CODE);
  end
`else
  assign fifo_push = frame_ok;
`endif

  assign fifo_pop = rd_en & ~addr_sel;
  assign stat_rd  = rd_en & addr_sel;

  kb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (fifo_push),
    .push_data (shreg),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .avail     (kb_avail)
  );

  // Sticky flags: a set in the same cycle as a status-read clear wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_flag <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      ovf_flag <= (fifo_push & fifo_full & ~fifo_pop) | (ovf_flag & ~stat_rd);
      err_flag <= frame_bad | (err_flag & ~stat_rd);
    end
  end

  assign ofs = addr_sel ? KB_STATUS_OFS : KB_DATA_OFS;

  // Read mux: DATA shows head and valid, STATUS shows flags and occupancy
  always_comb begin
    data_word                = '0;
    data_word[BIT_VALID]     = ~fifo_empty;
    data_word[7:0]           = fifo_empty ? 8'h00 : fifo_head;
    status_word              = '0;
    status_word[BIT_OVF]     = ovf_flag;
    status_word[BIT_ERR]     = err_flag;
    status_word[BIT_FULL]    = fifo_full;
    status_word[4:0]         = 5'(fifo_count);
    rdata = (ofs == KB_STATUS_OFS) ? status_word : data_word;
  end

endmodule

// File: tb/tb_kb_controller.sv
// tb/tb_kb_controller.sv - scoreboard testbench for kb_controller
module tb_kb_controller;

  localparam int HALF = 20;
  localparam int TO   = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic        rd_en;
  logic        addr_sel;
  logic [15:0] rdata;
  logic        kb_avail;

  always #5 clk = ~clk;

  kb_controller #(
    .FIFO_DEPTH  (16),
    .FIFO_AW     (4),
    .FILTER_LEN  (8),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rd_en    (rd_en),
    .addr_sel (addr_sel),
    .rdata    (rdata),
    .kb_avail (kb_avail)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  bit         m_ovf, m_err, m_drop;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  function automatic logic [15:0] exp_status();
    logic [4:0] c;
    c = 5'(exp_q.size());
    return {5'b0, m_ovf, m_err, (exp_q.size() == 16), 3'b0, c};
  endfunction

  function automatic logic [15:0] exp_data();
    if (exp_q.size() == 0) return 16'h0000;
    return {7'b0, 1'b1, exp_q[0]};
  endfunction

  task automatic model_push(input logic [7:0] b);
`ifdef KB_BREAK_FILTER_EN
    if (b == 8'hF0) begin
      m_drop = 1'b1;
      return;
    end
    if (m_drop) begin
      m_drop = 1'b0;
      return;
    end
`endif
    if (exp_q.size() < 16) exp_q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // mode 0: plain frame; 1: pop DATA in the stop-bit edge cycle; 2: check push latency at stop
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int mode);
    int k;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    k = 0;
    if (mode != 0) begin
      while (dut.fall_evt !== 1'b1 && k < HALF) begin
        @(negedge clk);
        k++;
      end
      check("stop_edge_seen", {15'b0, dut.fall_evt}, 16'h0001);
      if (mode == 1) begin
        check("head_at_stop", rdata, exp_data());
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        void'(exp_q.pop_front());
        model_push(b);
      end else begin
        check("avail_before_push", {15'b0, kb_avail}, {15'b0, (exp_q.size() != 0)});
        @(negedge clk);
        model_push(b);
        check("avail_after_push", {15'b0, kb_avail}, 16'h0001);
        check("data_after_push", rdata, exp_data());
      end
      k++;
    end
    while (k < HALF) begin
      @(negedge clk);
      k++;
    end
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    if (bad_par) begin
      m_err  = 1'b1;
      m_drop = 1'b0;
    end else if (mode == 0) begin
      model_push(b);
    end
  endtask

  task automatic pop_data();
    addr_sel = 1'b0;
    #1;
    check("data_head", rdata, exp_data());
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic read_status();
    addr_sel = 1'b1;
    #1;
    check("status_read", rdata, exp_status());
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    addr_sel = 1'b0;
    m_ovf = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic check_state(input string tag);
    addr_sel = 1'b0;
    #1;
    check({tag, "_data"}, rdata, exp_data());
    check({tag, "_avail"}, {15'b0, kb_avail}, {15'b0, (exp_q.size() != 0)});
    addr_sel = 1'b1;
    #1;
    check({tag, "_status"}, rdata, exp_status());
    addr_sel = 1'b0;
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rd_en    = 1'b0;
    addr_sel = 1'b0;
    m_ovf    = 1'b0;
    m_err    = 1'b0;
    m_drop   = 1'b0;
    repeat (5) @(negedge clk);
    check_state("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_state("post_reset");

    // Valid 0x1C, push latency, then pop back to empty
    send_frame(8'h1C, 1'b0, 2);
    check_state("t1_loaded");
    pop_data();
    check_state("t1_popped");

    // Bad parity sets frame_err and pushes nothing
    send_frame(8'h1C, 1'b1, 0);
    check_state("t2_err");
    read_status();
    check_state("t2_cleared");

    // Overflow: 17 bytes without reading
    for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b0, 0);
    check_state("t3_full");
    for (int i = 0; i < 16; i++) pop_data();
    check_state("t3_drained");
    read_status();

    // Partial frame aborted by inactivity timeout
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (TO + 100) @(negedge clk);
    m_err = 1'b1;
    check_state("t4_timeout");
    read_status();
    send_frame(8'h2A, 1'b0, 0);
    check_state("t4_after");
    pop_data();

    // Full FIFO with a push and a pop in the same cycle
    for (int i = 0; i < 16; i++) send_frame(8'h30 + 8'(i), 1'b0, 0);
    check_state("t5_full");
    send_frame(8'h55, 1'b0, 1);
    check_state("t5_pushpop");
    for (int i = 0; i < 16; i++) pop_data();
    check_state("t5_drained");

    // Break prefix handling
    send_frame(8'h1C, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h1C, 1'b0, 0);
    check_state("t6_break");
    while (exp_q.size() > 0) pop_data();
    check_state("t6_drained");

    // Reset mid-frame flushes the FIFO and returns to idle
    send_frame(8'h77, 1'b0, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    m_err = 1'b0;
    m_drop = 1'b0;
    check_state("t7_reset");
    repeat (TO + 100) @(negedge clk);
    read_status();
    send_frame(8'h3C, 1'b0, 0);
    check_state("t7_after");
    pop_data();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
